// File: rtl/serial_frame_collector_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : serial_pkg
//  Brief    : Shared widths, collector state encoding and FIFO entry layout.
//  Revision : 1.0 - initial release
// ============================================================================
package serial_pkg;

    localparam int DEF_W     = 8;
    localparam int DEF_LEN_W = $clog2(DEF_W + 1);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COLLECT = 2'd1,
        FLUSH_H = 2'd2,
        FLUSH_P = 2'd3
    } state_t;

    // FIFO entry layout, most significant field first: {last, len, data}
    typedef struct packed {
        logic                 last;
        logic [DEF_LEN_W-1:0] len;
        logic [DEF_W-1:0]     data;
    } entry_t;

endpackage
`default_nettype wire

// File: rtl/serial_frame_collector_sync_fifo.sv
`default_nettype none
// ============================================================================
//  Module   : sync_fifo
//  Brief    : Single-clock FIFO; a push while full is taken only alongside a pop.
//  Revision : 1.0 - initial release
// ============================================================================
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             do_push;
    logic             do_pop;

    assign full    = (count_q == CNT_W'(DEPTH));
    assign empty   = (count_q == '0);
    assign do_pop  = pop & ~empty;
    assign do_push = push & (~full | do_pop);
    assign rdata   = empty ? '0 : mem_q[rd_ptr_q];

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) begin
            mem_d[wr_ptr_q] = wdata;
            wr_ptr_d        = wr_ptr_q + PTR_W'(1);
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

endmodule
`default_nettype wire

// File: rtl/serial_frame_collector.sv
`default_nettype none
// ============================================================================
//  Module   : serial_frame_collector
//  Brief    : Packs LSB-first serial frame bits into words, tags the final word
//             of each frame and buffers them for a valid/ready consumer.
//  Revision : 1.0 - initial release
// ============================================================================
module serial_frame_collector
    import serial_pkg::*;
#(
    parameter int W     = DEF_W,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     din,
    input  logic                     din_valid,
    output logic [W-1:0]             word_data,
    output logic [$clog2(W+1)-1:0]   word_len,
    output logic                     word_last,
    output logic                     word_valid,
    input  logic                     word_ready,
    output logic                     overflow
);

    localparam int               LEN_W    = $clog2(W + 1);
    localparam int               ENTRY_W  = 1 + LEN_W + W;
    localparam logic [LEN_W-1:0] FULL_LEN = LEN_W'(W);

    state_t             state_q, state_d;
    logic [W-1:0]       shift_q, shift_d;
    logic [W-1:0]       hold_q, hold_d;
    logic [LEN_W-1:0]   bit_cnt_q, bit_cnt_d;
    logic               hold_v_q, hold_v_d;
    logic               overflow_q, overflow_d;

    logic               push;
    logic               pop;
    logic               fifo_full;
    logic               fifo_empty;
    logic [W-1:0]       shift_ins;
    logic [ENTRY_W-1:0] push_entry;
    logic [ENTRY_W-1:0] head_entry;

    // State register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= IDLE;
            shift_q    <= '0;
            hold_q     <= '0;
            bit_cnt_q  <= '0;
            hold_v_q   <= 1'b0;
            overflow_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            shift_q    <= shift_d;
            hold_q     <= hold_d;
            bit_cnt_q  <= bit_cnt_d;
            hold_v_q   <= hold_v_d;
            overflow_q <= overflow_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (din_valid)  state_d = COLLECT;
            COLLECT: if (!din_valid) state_d = FLUSH_H;
            FLUSH_H: state_d = (bit_cnt_q != '0) ? FLUSH_P : IDLE;
            FLUSH_P: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Datapath and push generation; the shift register is always zero above
    // bit_cnt, so partial words come out zero-padded.
    always_comb begin
        shift_d    = shift_q;
        hold_d     = hold_q;
        bit_cnt_d  = bit_cnt_q;
        hold_v_d   = hold_v_q;
        push       = 1'b0;
        push_entry = '0;
        shift_ins  = shift_q | ({{(W-1){1'b0}}, din} << bit_cnt_q);
        case (state_q)
            IDLE: begin
                if (din_valid) begin
                    shift_d   = {{(W-1){1'b0}}, din};
                    bit_cnt_d = LEN_W'(1);
                end
            end
            COLLECT: begin
                if (din_valid) begin
                    // A completed word waits in hold until we know the frame continues
                    if (hold_v_q) begin
                        push       = 1'b1;
                        push_entry = {1'b0, FULL_LEN, hold_q};
                        hold_v_d   = 1'b0;
                    end
                    if (bit_cnt_q == LEN_W'(W - 1)) begin
                        hold_d    = shift_ins;
                        hold_v_d  = 1'b1;
                        shift_d   = '0;
                        bit_cnt_d = '0;
                    end else begin
                        shift_d   = shift_ins;
                        bit_cnt_d = bit_cnt_q + LEN_W'(1);
                    end
                end
            end
            FLUSH_H: begin
                if (hold_v_q) begin
                    push       = 1'b1;
                    push_entry = {(bit_cnt_q == '0), FULL_LEN, hold_q};
                    hold_v_d   = 1'b0;
                end
            end
            FLUSH_P: begin
                push       = 1'b1;
                push_entry = {1'b1, bit_cnt_q, shift_q};
                shift_d    = '0;
                bit_cnt_d  = '0;
            end
            default: ;
        endcase
    end

    assign overflow_d = overflow_q | (push & fifo_full & ~pop);

    sync_fifo #(
        .WIDTH (ENTRY_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .pop   (pop),
        .wdata (push_entry),
        .rdata (head_entry),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    assign word_valid = ~fifo_empty;
    assign pop        = word_valid & word_ready;
    assign {word_last, word_len, word_data} = head_entry;
    assign overflow   = overflow_q;

endmodule
`default_nettype wire
